// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: serial UART transmitter, start + LSB-first data + optional even parity + stop.
module uart_tx_fsm #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W = 8,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_send,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_fsm_in_stop_s,
  output logic              tx_done
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [CW-1:0] bits, bits_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic par, par_n, armed, armed_n, tx_n, done_n;
  logic tick, capture, last_bit;
  assign tick = baud == BW'(CLKS_PER_BIT - 1);
  assign capture = state == IDLE && tx_send && armed;
  assign last_bit = bits == CW'(DATA_W - 1);
  assign tx_busy = state != IDLE;
  assign tx_fsm_in_stop_s = state == STOP;
  always_comb begin
    state_n = state;
    bits_n = bits;
    sh_n = sh;
    par_n = par;
    baud_n = (state == IDLE || tick) ? '0 : baud + 1'b1;
    case (state)
      IDLE: if (capture) begin
        state_n = START;
        sh_n = tx_data;
        par_n = 1'b0;
        bits_n = '0;
      end
      START: if (tick) state_n = DATA;
      DATA: if (tick) begin
        sh_n = sh >> 1;
        par_n = par ^ sh[0];
        bits_n = bits + 1'b1;
        if (last_bit) state_n = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (tick) state_n = STOP;
      STOP: if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // a held request must drop for a cycle before it can start another frame
    armed_n = capture ? 1'b0 : (!tx_send ? 1'b1 : armed);
    // the line is registered from the next state so it moves on the same edge as the FSM
    tx_n = (state_n == START) ? 1'b0 :
           (state_n == DATA) ? sh_n[0] :
           (state_n == PARITY) ? par_n : 1'b1;
    done_n = state == STOP && tick;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      baud <= '0;
      bits <= '0;
      sh <= '0;
      par <= 1'b0;
      armed <= 1'b1;
      tx <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bits <= bits_n;
      sh <= sh_n;
      par <= par_n;
      armed <= armed_n;
      tx <= tx_n;
      tx_done <= done_n;
    end
  end
endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Serial UART transmitter that sends one byte per request from the multicycle core's control unit. It captures the byte on a level-sensitive send request and serialises it as start bit, LSB-first data, optional even parity and stop bit at a fixed baud divisor. While in the stop bit it asserts a status output, which the control unit polls to leave its TX-wait state and return to fetch.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clk cycles per serial bit (100 MHz / 115200). Legal range 2..65535.
- DATA_W, default 8: data bits per frame. Legal range 5..8.
- PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- tx_send, in, 1: level-sensitive transmit request.
- tx_data, in, DATA_W: byte to send. Sampled only on the capture cycle.
- tx, out, 1: serial line. Idles high.
- tx_busy, out, 1: high in every state except IDLE.
- tx_fsm_in_stop_s, out, 1: high for every cycle the FSM is in STOP.
- tx_done, out, 1: one-cycle pulse on the cycle after STOP ends.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- The state register, bit counter, baud counter, shift register, armed flag, tx and tx_done are all registered.
- tx_busy and tx_fsm_in_stop_s are decoded from the state register only.
- Armed flag:
  - Set on reset.
  - Set on any cycle with tx_send=0.
  - Cleared on capture.
  - A request held high across a whole frame therefore sends exactly one frame.
- IDLE:
  - tx=1.
  - If tx_send=1 and armed=1: load tx_data into the shift register, clear parity accumulator and bit counter, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift_reg[0] for CLKS_PER_BIT cycles, then shift right and increment the bit counter.
  - The parity accumulator XORs in each bit sent.
  - After DATA_W bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = XOR of all data bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Pulse tx_done on the first IDLE cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1 and clears on every state transition. A bit boundary is the cycle the counter reads CLKS_PER_BIT-1.
- Bit counter is $clog2(DATA_W+1) bits wide. It never wraps within a frame.
- The STOP-to-IDLE cycle only evaluates the return; no capture happens on that cycle. Back-to-back frames therefore have at least one IDLE cycle (tx=1) between them.
- tx_send deasserting mid-frame has no effect; the frame completes.
- tx_data changes after capture have no effect.
- Reset mid-frame:
  - The frame is aborted immediately.
  - tx=1 asynchronously and the FSM returns to IDLE.
  - No tx_done pulse is produced.

## Timing
- Reset values: tx=1, tx_busy=0, tx_fsm_in_stop_s=0, tx_done=0, state=IDLE, armed=1, counters=0.
- Capture edge is edge 0. After it:
  - tx falls and tx_busy rises at edge 0.
  - The frame occupies N = (2 + DATA_W + PARITY_EN) × CLKS_PER_BIT cycles.
  - tx_fsm_in_stop_s is high during the last CLKS_PER_BIT cycles of the frame.
  - tx_done is high for the one cycle after the frame; tx_busy=0 on that same cycle.
- Minimum request-to-request spacing is N+1 cycles, and requires tx_send low for at least one cycle in between.

## Test plan
- Reset values: hold rst=0 with tx_send=1 → tx=1, tx_busy=0, tx_fsm_in_stop_s=0, tx_done=0. After release, exactly one frame starts on the first clock.
- Basic frame (CLKS_PER_BIT=4, DATA_W=8, PARITY_EN=0): send 0xA5 → tx over 40 cycles is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. tx_fsm_in_stop_s is high for cycles 37–40. tx_done pulses on cycle 41.
- Parity (PARITY_EN=1): send 0x07 → parity bit 1, frame length 44 cycles. Send 0x03 → parity bit 0.
- Held request: keep tx_send=1 for 200 cycles with 0x55 → exactly one frame. Drop tx_send for 1 cycle, raise it again with 0x0F → second frame 0x0F starts, with at least one idle-high cycle between frames.
- Control-unit handshake: drop tx_send on the first cycle tx_fsm_in_stop_s=1 → the stop bit still lasts the full 4 cycles, tx_done pulses once, and there is no retransmit.
- Reset mid-frame: assert rst=0 during data bit 3 → tx=1 immediately, tx_busy=0, no tx_done. After release with tx_send=1 → a fresh full frame.
